// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: round-robin arbiter sharing one rsa4k engine between two job requesters
module rsa_job_arbiter #(
    parameter int WIDTH       = 4096,
    parameter int ERST_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_message,
    input  logic [2*WIDTH-1:0] req_exponent,
    input  logic [2*WIDTH-1:0] req_modulus,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_err,
    output logic               eng_reset,
    output logic               eng_go,
    output logic [WIDTH-1:0]   eng_message,
    output logic [WIDTH-1:0]   eng_exponent,
    output logic [WIDTH-1:0]   eng_modulus,
    input  logic [WIDTH-1:0]   eng_cypher,
    input  logic               eng_done,
    output logic               busy,
    output logic [31:0]        job_cycles
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] ERST  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [3:0] ERST_LAST = 4'(ERST_CYCLES - 1);
    logic [2:0]  state;
    logic        last_grant;
    logic        g;
    logic        pick;
    logic [3:0]  erst_cnt;
    logic [31:0] job_cycles_cnt;
    logic [31:0] run_next;
    always_comb begin
        pick      = &req_valid ? ~last_grant : req_valid[1];
        req_ready = (state == IDLE && |req_valid) ? (pick ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid = state == RESP ? (g ? 2'b10 : 2'b01) : 2'b00;
        run_next  = &job_cycles_cnt ? job_cycles_cnt : job_cycles_cnt + 32'd1;
    end
    assign eng_reset = !reset || state == ERST;
    assign eng_go    = state == RUN;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            g              <= 1'b0;
            erst_cnt       <= '0;
            job_cycles_cnt <= '0;
            job_cycles     <= '0;
            rsp_result     <= '0;
            rsp_err        <= 1'b0;
            eng_message    <= '0;
            eng_exponent   <= '0;
            eng_modulus    <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    eng_message  <= pick ? req_message[WIDTH +: WIDTH]  : req_message[0 +: WIDTH];
                    eng_exponent <= pick ? req_exponent[WIDTH +: WIDTH] : req_exponent[0 +: WIDTH];
                    eng_modulus  <= pick ? req_modulus[WIDTH +: WIDTH]  : req_modulus[0 +: WIDTH];
                    g            <= pick;
                    state        <= CHECK;
                end
                CHECK: if (!eng_modulus[0]) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                    state      <= RESP;
                end else begin
                    rsp_err  <= 1'b0;
                    erst_cnt <= '0;
                    state    <= ERST;
                end
                ERST: if (erst_cnt == ERST_LAST) begin
                    job_cycles_cnt <= '0;
                    state          <= RUN;
                end else begin
                    erst_cnt <= erst_cnt + 4'd1;
                end
                RUN: begin
                    job_cycles_cnt <= run_next;
                    if (eng_done) begin
                        rsp_result <= eng_cypher;
                        job_cycles <= run_next;
                        state      <= RESP;
                    end
                end
                RESP: if (rsp_ready[g]) begin
                    last_grant <= g;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
